cic_frame_ctrl: RTL
===================

CIC_FRAME_CTRL -- requirements
Module: cic_frame_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 24, ADC/CIC input sample width.
REQ-002 SHALL have parameter CIC_OUT_W, default 44, CIC output width.
REQ-003 SHALL have parameter R, default 10, CIC decimation ratio.
REQ-004 SHALL have parameter N_IN, default 2000, input samples fed per frame; must be a multiple of R.
REQ-005 SHALL have parameter SETTLE, default 5, initial CIC outputs discarded per frame (transient).
REQ-006 SHALL have parameter CLR_CYC, default 4, cycles cic_rst_o is held per frame.
REQ-007 SHALL have parameter TMO, default 40, watchdog limit in cycles without cic_rdy_i.
REQ-008 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-009 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-010 SHALL have port trig_i, input, 1, pulse-start request, one-cycle pulse.
REQ-011 SHALL have port adc_data_i, input, DATA_W, signed continuous sample stream, one sample per clk.
REQ-012 SHALL have port cic_rst_o, output, 1, active-high reset to the CIC decimator.
REQ-013 SHALL have port cic_xin_o, output, DATA_W, signed CIC input.
REQ-014 SHALL have port cic_yout_i, input, CIC_OUT_W, CIC output data.
REQ-015 SHALL have port cic_rdy_i, input, 1, CIC output strobe.
REQ-016 SHALL have port out_valid_o, output, 1, forwarded sample valid.
REQ-017 SHALL have port out_data_o, output, CIC_OUT_W, forwarded sample.
REQ-018 SHALL have ports out_sop_o and out_eop_o, outputs, 1 each, first/last forwarded sample of a frame.
REQ-019 SHALL have ports busy_o, overrun_o and err_o, outputs, 1 each: frame active, trigger rejected, watchdog fired.

Function
REQ-020 SHALL implement states IDLE, CLEAR, FEED, FLUSH.
REQ-021 SHALL move IDLE->CLEAR on trig_i; hold cic_rst_o=1 for exactly CLR_CYC cycles, then enter FEED.
REQ-022 SHALL in FEED drive cic_xin_o with adc_data_i registered one cycle; count exactly N_IN cycles, then enter FLUSH.
REQ-023 SHALL drive cic_xin_o=0 in IDLE, CLEAR and FLUSH.
REQ-024 SHALL count cic_rdy_i strobes in FEED and FLUSH; discard the first SETTLE; forward the next OUT_LEN=N_IN/R with out_valid_o, registered one cycle after cic_rdy_i.
REQ-025 SHALL assert out_sop_o with the first forwarded sample and out_eop_o with the last, both one cycle wide.
REQ-026 SHALL return to IDLE the cycle after out_eop_o from FEED or FLUSH; remaining FEED samples are truncated.
REQ-027 SHALL ignore cic_rdy_i in IDLE and CLEAR; out_valid_o only asserts in FEED/FLUSH frames.
REQ-028 SHALL pulse overrun_o one cycle for trig_i in CLEAR, FEED or FLUSH; the trigger is dropped and the frame is unaffected.
REQ-029 SHALL accept trig_i coincident with the out_eop_o-transition cycle as a new frame, going directly to CLEAR with no overrun_o.
REQ-030 SHALL drive busy_o=1 in every state except IDLE.
REQ-031 SHALL saturate no arithmetic; counters sized ceil(log2) of their limit+1 and cleared on frame start.

Reset
REQ-032 SHALL on rst_n=0, asynchronously: state IDLE, all counters 0, cic_rst_o=1, cic_xin_o=0, out_valid_o/out_sop_o/out_eop_o/busy_o/overrun_o/err_o=0, out_data_o=0.
REQ-033 SHALL after rst_n deassertion drive cic_rst_o=0 in IDLE from the first clock edge.
REQ-034 SHALL abandon a frame on reset mid-frame with no out_eop_o emitted.

Configuration
REQ-035 SHALL, with macro CIC_FRAME_CTRL_TIMEOUT_EN defined, count cycles since last cic_rdy_i in FEED/FLUSH; on reaching TMO pulse err_o one cycle and go to IDLE with no out_eop_o.
REQ-036 SHALL, without CIC_FRAME_CTRL_TIMEOUT_EN, omit the watchdog counter and tie err_o to 0.

Verification
REQ-037 Nominal frame: trig_i pulse, real CIC R=10, adc=1000 constant -> cic_rst_o high 4 cycles, 2000 FEED cycles, first 5 outputs dropped, 200 out_valid_o with sop on 1st, eop on 200th, then busy_o=0.
REQ-038 Overrun: trig_i pulse 100 cycles into FEED -> overrun_o one-cycle pulse, frame still yields exactly 200 outputs.
REQ-039 Back-to-back: trig_i on the eop-transition cycle -> no overrun_o, immediate CLEAR, second frame of 200 outputs.
REQ-040 Reset mid-frame: rst_n low at FEED cycle 500 -> all outputs 0 and cic_rst_o=1 immediately, IDLE after release, no eop.
REQ-041 Watchdog (macro defined): cic_rdy_i forced low after frame start -> err_o pulse exactly 40 cycles after last rdy, return to IDLE; macro undefined -> err_o stays 0 and FSM waits in FLUSH.
REQ-042 Truncation: N_IN=20, SETTLE=0, stub CIC strobing rdy every cycle -> 2 outputs, eop on 2nd, IDLE before FEED count completes.

Source files
------------

// File: rtl/cic_frame_ctrl.sv
// Frame controller around a CIC decimator: clears it, feeds a fixed-length window, and forwards the settled outputs.
// Optional watchdog on the CIC output strobe is enabled by defining CIC_FRAME_CTRL_TIMEOUT_EN.
module cic_frame_ctrl #(
   parameter int DATA_W    = 24,
   parameter int CIC_OUT_W = 44,
   parameter int R         = 10,
   parameter int N_IN      = 2000,
   parameter int SETTLE    = 5,
   parameter int CLR_CYC   = 4,
   parameter int TMO       = 40
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        trig_i,
   input  logic signed [DATA_W-1:0]    adc_data_i,
   output logic                        cic_rst_o,
   output logic signed [DATA_W-1:0]    cic_xin_o,
   input  logic [CIC_OUT_W-1:0]        cic_yout_i,
   input  logic                        cic_rdy_i,
   output logic                        out_valid_o,
   output logic [CIC_OUT_W-1:0]        out_data_o,
   output logic                        out_sop_o,
   output logic                        out_eop_o,
   output logic                        busy_o,
   output logic                        overrun_o,
   output logic                        err_o
);

   localparam int OUT_LEN = N_IN / R;
   localparam int RDY_MAX = SETTLE + OUT_LEN;
   localparam int CLR_W   = $clog2(CLR_CYC + 1);
   localparam int FEED_W  = $clog2(N_IN + 1);
   localparam int RDY_W   = $clog2(RDY_MAX + 1);

   typedef enum logic [1:0] {IDLE, CLEAR, FEED, FLUSH} state_t;

   state_t             state_reg;
   logic [CLR_W-1:0]   clr_cnt_reg;
   logic [FEED_W-1:0]  feed_cnt_reg;
   logic [RDY_W-1:0]   rdy_cnt_reg;
   logic               start_ok;
   logic               wd_fire;

   // A trigger landing on the eop cycle chains straight into the next frame.
   assign start_ok = trig_i && ((state_reg == IDLE) || out_eop_o);

`ifdef CIC_FRAME_CTRL_TIMEOUT_EN
   localparam int WD_W = $clog2(TMO + 1);
   logic [WD_W-1:0] wd_cnt_reg;
   logic            frame_run;

   assign frame_run = ((state_reg == FEED) || (state_reg == FLUSH)) && !out_eop_o;
   assign wd_fire   = frame_run && !cic_rdy_i && (wd_cnt_reg == WD_W'(TMO - 1));

   // wd_cnt_reg holds the number of cycles since the last strobe (or since the end of CLEAR).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt_reg <= '0;
         err_o      <= 1'b0;
      end else begin
         err_o <= wd_fire;
         if (state_reg == CLEAR) begin
            wd_cnt_reg <= WD_W'(1);
         end else if (frame_run) begin
            if (cic_rdy_i)
               wd_cnt_reg <= WD_W'(1);
            else if (!wd_fire)
               wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
         end
      end
   end
`else
   assign wd_fire = 1'b0;
   assign err_o   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         clr_cnt_reg  <= '0;
         feed_cnt_reg <= '0;
         rdy_cnt_reg  <= '0;
         cic_rst_o    <= 1'b1;
         cic_xin_o    <= '0;
         out_valid_o  <= 1'b0;
         out_data_o   <= '0;
         out_sop_o    <= 1'b0;
         out_eop_o    <= 1'b0;
         busy_o       <= 1'b0;
         overrun_o    <= 1'b0;
      end else begin
         out_valid_o <= 1'b0;
         out_sop_o   <= 1'b0;
         out_eop_o   <= 1'b0;
         overrun_o   <= trig_i && !start_ok && (state_reg != IDLE);
         if (start_ok) begin
            state_reg    <= CLEAR;
            clr_cnt_reg  <= '0;
            feed_cnt_reg <= '0;
            rdy_cnt_reg  <= '0;
            cic_rst_o    <= 1'b1;
            cic_xin_o    <= '0;
            busy_o       <= 1'b1;
         end else begin
            case (state_reg)
               IDLE: begin
                  cic_rst_o <= 1'b0;
                  cic_xin_o <= '0;
                  busy_o    <= 1'b0;
               end
               CLEAR: begin
                  if (clr_cnt_reg == CLR_W'(CLR_CYC - 1)) begin
                     state_reg <= FEED;
                     cic_rst_o <= 1'b0;
                     cic_xin_o <= adc_data_i;
                  end else begin
                     clr_cnt_reg <= clr_cnt_reg + CLR_W'(1);
                  end
               end
               default: begin
                  if (out_eop_o || wd_fire) begin
                     state_reg <= IDLE;
                     cic_xin_o <= '0;
                     busy_o    <= 1'b0;
                  end else begin
                     if (cic_rdy_i) begin
                        if (rdy_cnt_reg >= RDY_W'(SETTLE)) begin
                           out_valid_o <= 1'b1;
                           out_data_o  <= cic_yout_i;
                           out_sop_o   <= (rdy_cnt_reg == RDY_W'(SETTLE));
                           out_eop_o   <= (rdy_cnt_reg == RDY_W'(RDY_MAX - 1));
                        end
                        rdy_cnt_reg <= rdy_cnt_reg + RDY_W'(1);
                     end
                     // FLUSH keeps the decimator input at zero until the last output arrives.
                     if (state_reg == FEED) begin
                        if (feed_cnt_reg == FEED_W'(N_IN - 1)) begin
                           state_reg <= FLUSH;
                           cic_xin_o <= '0;
                        end else begin
                           feed_cnt_reg <= feed_cnt_reg + FEED_W'(1);
                           cic_xin_o    <= adc_data_i;
                        end
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule
